// File: rtl/rom_download_ctrl.sv
// Download port filter between the SPI data_io stream and the core load port.
// Registers accepted bytes, tracks checksum/length and sequences the core reset.
module rom_download_ctrl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned ROM_INDEX    = 0,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned EXPECTED_LEN = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              soft_reset,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic              load_error,
    output logic [15:0]       checksum,
    output logic [16:0]       byte_count
);

    localparam logic [7:0]  RomIdx   = 8'(ROM_INDEX);
    localparam logic [7:0]  HoldInit = 8'(HOLD_CYCLES - 1);
    localparam logic [16:0] ExpLen   = 17'(EXPECTED_LEN);
    localparam bit          LenCheck = (EXPECTED_LEN != 0);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StHold,
        StRun,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic                dl_q;
    logic [7:0]          hold_q, hold_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         checksum_q, checksum_d, checksum_base;
    logic [16:0]         count_q, count_d, count_base;
    logic                load_error_q, load_error_d;
    logic                rom_loaded_q, rom_loaded_d;
    logic                core_reset_q, core_reset_d;
    logic                dn_wr_q;
    logic [ADDR_W-1:0]   dn_addr_q;
    logic [7:0]          dn_data_q;

    logic is_rom, start_edge, end_edge, rom_start;
    logic in_range, load_window, rom_wr, accept, overflow_wr, check_err;

    always_comb begin
        is_rom      = (ioctl_index == RomIdx);
        start_edge  = ioctl_download & ~dl_q;
        end_edge    = ~ioctl_download & dl_q;
        rom_start   = start_edge & is_rom;
        in_range    = ((ioctl_addr >> ADDR_W) == '0);
        // The start-edge cycle already counts as LOAD so a byte there becomes byte 1.
        load_window = (state_q == StLoad) | rom_start;
        rom_wr      = ioctl_wr & is_rom & load_window;
        accept      = rom_wr & in_range;
        overflow_wr = rom_wr & ~in_range;
    end

    always_comb begin
        checksum_base = rom_start ? 16'h0000 : checksum_q;
        count_base    = rom_start ? 17'h00000 : count_q;
        checksum_d    = checksum_base + (accept ? {8'h00, ioctl_dout} : 16'h0000);
        count_d       = (accept && count_base != 17'h1FFFF) ? count_base + 17'd1 : count_base;
        ovf_d         = (rom_start ? 1'b0 : ovf_q) | overflow_wr;
        // A write on the end-edge cycle has already landed in count_q by CHECK.
        check_err     = ovf_q | (LenCheck && (count_q != ExpLen));
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        load_error_d = load_error_q;
        rom_loaded_d = rom_loaded_q;
        if (rom_start) begin
            state_d      = StLoad;
            load_error_d = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (end_edge) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (check_err) begin
                        state_d      = StErr;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = StHold;
                        hold_d  = HoldInit;
                    end
                end
                StHold: begin
                    if (hold_q == 8'd0) begin
                        state_d      = StRun;
                        rom_loaded_d = 1'b1;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                StIdle, StRun, StErr: begin
                end
                default: state_d = StIdle;
            endcase
        end
        core_reset_d = (state_d == StRun) ? soft_reset : 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            dl_q         <= 1'b0;
            hold_q       <= 8'd0;
            ovf_q        <= 1'b0;
            checksum_q   <= 16'h0000;
            count_q      <= 17'h00000;
            load_error_q <= 1'b0;
            rom_loaded_q <= 1'b0;
            core_reset_q <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            dl_q         <= ioctl_download;
            hold_q       <= hold_d;
            ovf_q        <= ovf_d;
            checksum_q   <= checksum_d;
            count_q      <= count_d;
            load_error_q <= load_error_d;
            rom_loaded_q <= rom_loaded_d;
            core_reset_q <= core_reset_d;
            dn_wr_q      <= accept;
            if (accept) begin
                dn_addr_q <= ioctl_addr[ADDR_W-1:0];
                dn_data_q <= ioctl_dout;
            end
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    // Foreign-index downloads hold the core in reset only while they are active.
    assign core_reset = core_reset_q | (ioctl_download & ~is_rom);
    assign rom_loaded = rom_loaded_q;
    assign load_error = load_error_q;
    assign checksum   = checksum_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: one instance without and one with a length check.
module tb_rom_download_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        soft_reset;

    logic [15:0] a_dn_addr, b_dn_addr;
    logic [7:0]  a_dn_data, b_dn_data;
    logic        a_dn_wr, b_dn_wr;
    logic        a_core_reset, b_core_reset;
    logic        a_rom_loaded, b_rom_loaded;
    logic        a_load_error, b_load_error;
    logic [15:0] a_checksum, b_checksum;
    logic [16:0] a_byte_count, b_byte_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    rom_download_ctrl #(
        .ADDR_W(16), .ROM_INDEX(0), .HOLD_CYCLES(16), .EXPECTED_LEN(0)
    ) u_len0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .soft_reset(soft_reset), .dn_addr(a_dn_addr),
        .dn_data(a_dn_data), .dn_wr(a_dn_wr), .core_reset(a_core_reset),
        .rom_loaded(a_rom_loaded), .load_error(a_load_error), .checksum(a_checksum),
        .byte_count(a_byte_count)
    );

    rom_download_ctrl #(
        .ADDR_W(16), .ROM_INDEX(0), .HOLD_CYCLES(16), .EXPECTED_LEN(4)
    ) u_len4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .soft_reset(soft_reset), .dn_addr(b_dn_addr),
        .dn_data(b_dn_data), .dn_wr(b_dn_wr), .core_reset(b_core_reset),
        .rom_loaded(b_rom_loaded), .load_error(b_load_error), .checksum(b_checksum),
        .byte_count(b_byte_count)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        soft_reset     = 1'b0;
        reset_n        = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Index-0 download of n bytes (addr i, data i+1), then wait until RUN/ERR settles.
    task automatic load_image(input int n);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i + 1);
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        ioctl_download = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_dn_addr !== 16'h0 || a_dn_data !== 8'h0 || a_dn_wr !== 1'b0 ||
            a_core_reset !== 1'b1 || a_rom_loaded !== 1'b0 || a_load_error !== 1'b0 ||
            a_checksum !== 16'h0 || a_byte_count !== 17'h0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h data=%h wr=%b cr=%b rl=%b le=%b cs=%h bc=%h, want 0/0/0/1/0/0/0/0",
                     a_dn_addr, a_dn_data, a_dn_wr, a_core_reset, a_rom_loaded, a_load_error,
                     a_checksum, a_byte_count);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        logic [7:0] data [4];
        data[0] = 8'h01; data[1] = 8'h02; data[2] = 8'h03; data[3] = 8'hFF;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = data[i];
            tick();
            ioctl_wr = 1'b0;
            checks++;
            if (a_dn_wr !== 1'b1 || a_dn_addr !== 16'(i) || a_dn_data !== data[i]) begin
                errors++;
                $display("FAIL basic_dn_write[%0d]: got wr=%b addr=%h data=%h, want 1/%h/%h",
                         i, a_dn_wr, a_dn_addr, a_dn_data, 16'(i), data[i]);
            end
            tick();
            checks++;
            if (a_dn_wr !== 1'b0) begin
                errors++;
                $display("FAIL basic_dn_wr_single[%0d]: got %b, want 0", i, a_dn_wr);
            end
        end
        ioctl_download = 1'b0;
        tick();
        checks++;
        if (a_checksum !== 16'h0105 || a_byte_count !== 17'd4 || a_core_reset !== 1'b1) begin
            errors++;
            $display("FAIL basic_counters: got cs=%h bc=%0d cr=%b, want 0105/4/1",
                     a_checksum, a_byte_count, a_core_reset);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (a_core_reset !== 1'b1) begin
                errors++;
                $display("FAIL basic_hold[%0d]: got core_reset=%b, want 1", i, a_core_reset);
            end
        end
        tick();
        checks++;
        if (a_core_reset !== 1'b0 || a_rom_loaded !== 1'b1 || a_load_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: got cr=%b rl=%b le=%b, want 0/1/0",
                     a_core_reset, a_rom_loaded, a_load_error);
        end
    endtask

    task automatic test_length_error();
        do_reset();
        load_image(3);
        checks++;
        if (b_load_error !== 1'b1 || b_core_reset !== 1'b1 || b_rom_loaded !== 1'b0) begin
            errors++;
            $display("FAIL short_image: got le=%b cr=%b rl=%b, want 1/1/0",
                     b_load_error, b_core_reset, b_rom_loaded);
        end
        load_image(4);
        checks++;
        if (b_load_error !== 1'b0 || b_core_reset !== 1'b0 || b_rom_loaded !== 1'b1 ||
            b_byte_count !== 17'd4 || b_checksum !== 16'h000A) begin
            errors++;
            $display("FAIL recover_image: got le=%b cr=%b rl=%b bc=%0d cs=%h, want 0/0/1/4/000a",
                     b_load_error, b_core_reset, b_rom_loaded, b_byte_count, b_checksum);
        end
    endtask

    task automatic test_range();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h00005;
        ioctl_dout = 8'h11;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h10000;
        ioctl_dout = 8'h55;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (a_dn_wr !== 1'b0 || a_byte_count !== 17'd1 || a_checksum !== 16'h0011) begin
            errors++;
            $display("FAIL range_drop: got wr=%b bc=%0d cs=%h, want 0/1/0011",
                     a_dn_wr, a_byte_count, a_checksum);
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        checks++;
        if (a_load_error !== 1'b1 || a_core_reset !== 1'b1) begin
            errors++;
            $display("FAIL range_error: got le=%b cr=%b, want 1/1", a_load_error, a_core_reset);
        end
    endtask

    task automatic test_foreign_index();
        load_image(4);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        checks++;
        if (a_core_reset !== 1'b1) begin
            errors++;
            $display("FAIL foreign_reset_on: got %b, want 1", a_core_reset);
        end
        for (int i = 0; i < 2; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'hA5;
            tick();
            ioctl_wr = 1'b0;
            checks++;
            if (a_dn_wr !== 1'b0 || a_core_reset !== 1'b1) begin
                errors++;
                $display("FAIL foreign_write[%0d]: got wr=%b cr=%b, want 0/1",
                         i, a_dn_wr, a_core_reset);
            end
        end
        ioctl_download = 1'b0;
        #1;
        checks++;
        if (a_core_reset !== 1'b0) begin
            errors++;
            $display("FAIL foreign_reset_off: got %b, want 0", a_core_reset);
        end
        tick();
        tick();
        checks++;
        if (a_core_reset !== 1'b0 || a_rom_loaded !== 1'b1 || a_byte_count !== 17'd4) begin
            errors++;
            $display("FAIL foreign_after: got cr=%b rl=%b bc=%0d, want 0/1/4",
                     a_core_reset, a_rom_loaded, a_byte_count);
        end
        ioctl_index = 8'd0;
    endtask

    task automatic test_end_edge_write();
        logic [7:0] data [4];
        data[0] = 8'h10; data[1] = 8'h20; data[2] = 8'h30; data[3] = 8'h40;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = data[i];
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd3;
        ioctl_dout     = data[3];
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (b_dn_wr !== 1'b1 || b_dn_addr !== 16'd3 || b_dn_data !== 8'h40 ||
            b_byte_count !== 17'd4 || b_checksum !== 16'h00A0) begin
            errors++;
            $display("FAIL end_write: got wr=%b addr=%h data=%h bc=%0d cs=%h, want 1/0003/40/4/00a0",
                     b_dn_wr, b_dn_addr, b_dn_data, b_byte_count, b_checksum);
        end
        repeat (18) tick();
        checks++;
        if (b_load_error !== 1'b0 || b_core_reset !== 1'b0) begin
            errors++;
            $display("FAIL end_write_release: got le=%b cr=%b, want 0/0",
                     b_load_error, b_core_reset);
        end
    endtask

    task automatic test_soft_reset();
        soft_reset = 1'b1;
        #1;
        checks++;
        if (a_core_reset !== 1'b0) begin
            errors++;
            $display("FAIL soft_latency: got %b, want 0", a_core_reset);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_core_reset !== 1'b1) begin
                errors++;
                $display("FAIL soft_high[%0d]: got %b, want 1", i, a_core_reset);
            end
        end
        soft_reset = 1'b0;
        tick();
        checks++;
        if (a_core_reset !== 1'b0) begin
            errors++;
            $display("FAIL soft_release: got %b, want 0", a_core_reset);
        end
    endtask

    task automatic test_reset_mid_load();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h00042;
        ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_dn_addr !== 16'h0 || a_dn_data !== 8'h0 || a_dn_wr !== 1'b0 ||
            a_core_reset !== 1'b1 || a_rom_loaded !== 1'b0 || a_load_error !== 1'b0 ||
            a_checksum !== 16'h0 || a_byte_count !== 17'h0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h data=%h wr=%b cr=%b rl=%b le=%b cs=%h bc=%h, want 0/0/0/1/0/0/0/0",
                     a_dn_addr, a_dn_data, a_dn_wr, a_core_reset, a_rom_loaded, a_load_error,
                     a_checksum, a_byte_count);
        end
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        ioctl_download = 1'b1;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h07;
        tick();
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h08;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (a_checksum !== 16'h000F || a_byte_count !== 17'd2) begin
            errors++;
            $display("FAIL clean_restart: got cs=%h bc=%0d, want 000f/2", a_checksum, a_byte_count);
        end
        ioctl_download = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic_load();
        test_length_error();
        test_range();
        test_foreign_index();
        test_end_edge_write();
        test_soft_reset();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
